// File: rtl/pcpu_regfile_sb.sv
// Register file with per-register pending-write counters that ID uses for RAW stalls.
// Optional same-cycle WB-to-read bypass: define PCPU_RF_BYPASS_EN.
module pcpu_regfile_sb #(
    parameter int DATA_W = 16,
    parameter int AW     = 3,
    parameter int PEND_W = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [AW-1:0]                 ra_addr,
    output logic [DATA_W-1:0]             ra_data,
    output logic                          ra_busy,
    input  logic [AW-1:0]                 rb_addr,
    output logic [DATA_W-1:0]             rb_data,
    output logic                          rb_busy,
    input  logic                          iss_valid,
    input  logic [AW-1:0]                 iss_rd,
    output logic                          iss_ready,
    input  logic                          wb_en,
    input  logic [AW-1:0]                 wb_addr,
    input  logic [DATA_W-1:0]             wb_data,
    input  logic                          wb_tracked,
    output logic                          sb_err,
    output logic [(2**AW)*DATA_W-1:0]     dbg_regs
);

    localparam int REG_CNT = 2**AW;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [PEND_W-1:0] pend_q [REG_CNT];
    logic [PEND_W-1:0] pend_d [REG_CNT];
    logic              sb_err_q, sb_err_d;
    logic [REG_CNT-1:0] inc_vec, dec_vec;
    logic              wb_trk, acc;

    assign wb_trk = wb_en & wb_tracked;

    // A same-cycle tracked writeback to iss_rd frees a slot, so a saturated counter can still accept.
    assign iss_ready = (pend_q[iss_rd] != PEND_MAX) || (wb_trk && (wb_addr == iss_rd));
    assign acc       = iss_valid & iss_ready;

    always_comb begin
        inc_vec  = '0;
        dec_vec  = '0;
        sb_err_d = sb_err_q;
        for (int r = 0; r < REG_CNT; r++) begin
            inc_vec[r] = acc && (iss_rd == AW'(r));
            dec_vec[r] = wb_trk && (wb_addr == AW'(r)) && (pend_q[r] != '0);
            pend_d[r]  = pend_q[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                pend_d[r] = pend_q[r] + 1'b1;
            end else if (!inc_vec[r] && dec_vec[r]) begin
                pend_d[r] = pend_q[r] - 1'b1;
            end
        end
        if (wb_trk && (pend_q[wb_addr] == '0)) begin
            sb_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int r = 0; r < REG_CNT; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            if (wb_en) begin
                regs_q[wb_addr] <= wb_data;
            end
            for (int r = 0; r < REG_CNT; r++) begin
                pend_q[r] <= pend_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

`ifdef PCPU_RF_BYPASS_EN
    assign ra_data = (wb_en && (wb_addr == ra_addr)) ? wb_data : regs_q[ra_addr];
    assign rb_data = (wb_en && (wb_addr == rb_addr)) ? wb_data : regs_q[rb_addr];
    // The last outstanding write retiring this cycle clears busy immediately.
    assign ra_busy = (pend_q[ra_addr] != '0) &&
                     !(wb_trk && (wb_addr == ra_addr) && (pend_q[ra_addr] == PEND_W'(1)));
    assign rb_busy = (pend_q[rb_addr] != '0) &&
                     !(wb_trk && (wb_addr == rb_addr) && (pend_q[rb_addr] == PEND_W'(1)));
`else
    assign ra_data = regs_q[ra_addr];
    assign rb_data = regs_q[rb_addr];
    assign ra_busy = (pend_q[ra_addr] != '0);
    assign rb_busy = (pend_q[rb_addr] != '0);
`endif

    assign sb_err = sb_err_q;

    genvar g;
    generate
        for (g = 0; g < REG_CNT; g++) begin : g_dbg
            assign dbg_regs[g*DATA_W +: DATA_W] = regs_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_pcpu_regfile_sb.sv
// Directed self-checking bench for pcpu_regfile_sb (default 16-bit x 8, PEND_W=2).
module tb_pcpu_regfile_sb;

    localparam int DATA_W = 16;
    localparam int AW     = 3;

`ifdef PCPU_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic [AW-1:0]     ra_addr, rb_addr, iss_rd, wb_addr;
    logic [DATA_W-1:0] ra_data, rb_data, wb_data;
    logic              ra_busy, rb_busy, iss_valid, iss_ready;
    logic              wb_en, wb_tracked, sb_err;
    logic [8*DATA_W-1:0] dbg_regs;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pcpu_regfile_sb #(.DATA_W(DATA_W), .AW(AW), .PEND_W(2)) dut (
        .clock(clock), .reset(reset),
        .ra_addr(ra_addr), .ra_data(ra_data), .ra_busy(ra_busy),
        .rb_addr(rb_addr), .rb_data(rb_data), .rb_busy(rb_busy),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_tracked(wb_tracked),
        .sb_err(sb_err), .dbg_regs(dbg_regs)
    );

    // Advance one rising edge; inputs change 1 time unit after it, checks 1 unit later.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_rd = 0; wb_en = 0; wb_addr = 0; wb_data = 0; wb_tracked = 0;
    endtask

    task automatic test_reset();
        reset = 0; ra_addr = 0; rb_addr = 0;
        idle_inputs();
        cyc(); cyc();
        reset = 1; ra_addr = 5;
        #1;
        checks++; if (ra_data !== 16'h0000) begin errors++; $display("FAIL reset_ra_data: got %h expected 0000", ra_data); end
        checks++; if (ra_busy !== 1'b0) begin errors++; $display("FAIL reset_ra_busy: got %b expected 0", ra_busy); end
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready: got %b expected 1", iss_ready); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err: got %b expected 0", sb_err); end
        checks++; if (dbg_regs !== '0) begin errors++; $display("FAIL reset_dbg_regs: got %h expected 0", dbg_regs); end
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] exp_same;
        exp_same = BYP ? 16'hBEEF : 16'h0000;
        wb_en = 1; wb_addr = 3; wb_data = 16'hBEEF; wb_tracked = 0; rb_addr = 3;
        #1;
        checks++; if (rb_data !== exp_same) begin errors++; $display("FAIL wr_same_cycle: got %h expected %h", rb_data, exp_same); end
        cyc();
        idle_inputs();
        #1;
        checks++; if (rb_data !== 16'hBEEF) begin errors++; $display("FAIL wr_next_cycle: got %h expected BEEF", rb_data); end
        checks++; if (dbg_regs[3*DATA_W +: DATA_W] !== 16'hBEEF) begin errors++; $display("FAIL wr_dbg_reg3: got %h expected BEEF", dbg_regs[3*DATA_W +: DATA_W]); end
        checks++; if (rb_busy !== 1'b0) begin errors++; $display("FAIL wr_untracked_busy: got %b expected 0", rb_busy); end
    endtask

    task automatic test_saturation();
        ra_addr = 2;
        iss_valid = 1; iss_rd = 2;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sat_issue_ready%0d: got %b expected 1", i, iss_ready); end
            cyc();
        end
        #1;
        checks++; if (ra_busy !== 1'b1) begin errors++; $display("FAIL sat_busy: got %b expected 1", ra_busy); end
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL sat_refused: got %b expected 0", iss_ready); end
        cyc();
        #1;
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL sat_hold: got %b expected 0", iss_ready); end
        wb_en = 1; wb_addr = 2; wb_data = 16'h0AAA; wb_tracked = 1;
        #1;
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sat_wb_frees: got %b expected 1", iss_ready); end
        cyc();
        idle_inputs();
        iss_rd = 2;
        #1;
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL sat_still_full: got %b expected 0", iss_ready); end
        checks++; if (ra_data !== 16'h0AAA) begin errors++; $display("FAIL sat_wb_data: got %h expected 0AAA", ra_data); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL sat_sb_err: got %b expected 0", sb_err); end
    endtask

    task automatic test_drain();
        logic exp_last_busy;
        exp_last_busy = BYP ? 1'b0 : 1'b1;
        ra_addr = 2;
        wb_en = 1; wb_addr = 2; wb_tracked = 1; wb_data = 16'h0001;
        cyc();
        #1;
        checks++; if (ra_busy !== 1'b1) begin errors++; $display("FAIL drain_busy1: got %b expected 1", ra_busy); end
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL drain_ready: got %b expected 1", iss_ready); end
        wb_data = 16'h0002;
        cyc();
        #1;
        checks++; if (ra_busy !== 1'b1) begin errors++; $display("FAIL drain_busy2: got %b expected 1", ra_busy); end
        wb_data = 16'h0003;
        #1;
        checks++; if (ra_busy !== exp_last_busy) begin errors++; $display("FAIL drain_last_same_cycle: got %b expected %b", ra_busy, exp_last_busy); end
        cyc();
        idle_inputs();
        #1;
        checks++; if (ra_busy !== 1'b0) begin errors++; $display("FAIL drain_busy_clear: got %b expected 0", ra_busy); end
        checks++; if (ra_data !== 16'h0003) begin errors++; $display("FAIL drain_data: got %h expected 0003", ra_data); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL drain_sb_err: got %b expected 0", sb_err); end
    endtask

    task automatic test_underflow();
        rb_addr = 6;
        wb_en = 1; wb_addr = 6; wb_tracked = 1; wb_data = 16'h1234;
        #1;
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL uf_before: got %b expected 0", sb_err); end
        cyc();
        idle_inputs();
        #1;
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL uf_sb_err: got %b expected 1", sb_err); end
        checks++; if (rb_data !== 16'h1234) begin errors++; $display("FAIL uf_data: got %h expected 1234", rb_data); end
        checks++; if (rb_busy !== 1'b0) begin errors++; $display("FAIL uf_counter_zero: got %b expected 0", rb_busy); end
        wb_en = 1; wb_addr = 7; wb_data = 16'h00FF; wb_tracked = 0;
        cyc();
        idle_inputs();
        cyc(); cyc();
        #1;
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b expected 1", sb_err); end
    endtask

    task automatic test_reset_midflight();
        wb_en = 1; wb_addr = 1; wb_data = 16'h5555; wb_tracked = 0;
        cyc();
        idle_inputs();
        iss_valid = 1; iss_rd = 1;
        cyc(); cyc();
        idle_inputs();
        ra_addr = 1;
        #1;
        checks++; if (ra_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", ra_busy); end
        checks++; if (ra_data !== 16'h5555) begin errors++; $display("FAIL mid_data_before: got %h expected 5555", ra_data); end
        reset = 0;
        wb_en = 1; wb_addr = 1; wb_data = 16'h7777; wb_tracked = 1;
        iss_valid = 1; iss_rd = 1;
        cyc();
        reset = 1;
        idle_inputs();
        iss_rd = 1;
        #1;
        checks++; if (ra_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b expected 0", ra_busy); end
        checks++; if (ra_data !== 16'h0000) begin errors++; $display("FAIL mid_reg1: got %h expected 0000", ra_data); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL mid_sb_err: got %b expected 0", sb_err); end
        checks++; if (dbg_regs !== '0) begin errors++; $display("FAIL mid_dbg_regs: got %h expected 0", dbg_regs); end
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL mid_iss_ready: got %b expected 1", iss_ready); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_saturation();
        test_drain();
        test_underflow();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcpu_regfile_sb.md
# pcpu_regfile_sb

Parametrised general-register file with an integrated write-pending scoreboard for the PCPU pipeline. It replaces the fixed eight 16-bit registers driven from WB. It adds two read ports for ID, one write port for WB, and per-register in-flight write counters. ID uses these counters to detect RAW hazards and stall instead of relying only on forwarding. A flat debug bus exposes every register for the bench and the board display.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- AW, 3, register address width; REG_CNT = 2**AW registers
- PEND_W, 2, width of each pending-write counter; max in-flight writes per register = 2**PEND_W-1

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- ra_addr  in  AW  read port A address
- ra_data  out  DATA_W  read port A data (combinational)
- ra_busy  out  1  register ra_addr has a pending write
- rb_addr  in  AW  read port B address
- rb_data  out  DATA_W  read port B data (combinational)
- rb_busy  out  1  register rb_addr has a pending write
- iss_valid  in  1  ID issues an instruction that will write iss_rd
- iss_rd  in  AW  destination of issuing instruction
- iss_ready  out  1  issue accepted this cycle (counter of iss_rd not saturated, or being decremented same cycle)
- wb_en  in  1  WB writes this cycle
- wb_addr  in  AW  write address
- wb_data  in  DATA_W  write data
- wb_tracked  in  1  this write was issued through iss_*; decrements counter
- sb_err  out  1  sticky: tracked write to register whose counter was 0
- dbg_regs  out  REG_CNT*DATA_W  register i at bits [i*DATA_W +: DATA_W]

## Operation
- Storage: REG_CNT x DATA_W array, plus REG_CNT counters of PEND_W bits, plus sb_err flop.
- Write: on a rising edge with reset=1 and wb_en=1, array[wb_addr] <= wb_data. All registers, including register 0, are writable.
- Read: ra_data = array[ra_addr]; rb_data = array[rb_addr]. See Configuration for same-cycle bypass.
- busy: xx_busy = (pend[xx_addr] != 0), modified by bypass.
- Issue accept: acc = iss_valid & iss_ready. iss_ready = (pend[iss_rd] != max) | (wb_en & wb_tracked & wb_addr==iss_rd).
- Counter update per register r on each edge:
  - inc = acc & iss_rd==r; dec = wb_en & wb_tracked & wb_addr==r & pend[r]!=0.
  - pend[r] += inc - dec. inc with dec leaves the counter unchanged.
- Underflow: tracked write with pend[wb_addr]==0 writes the data, leaves the counter at 0, and sets sb_err=1. sb_err holds until reset.
- Untracked write (wb_tracked=0) writes data only; counters are untouched.
- A refused issue (iss_valid=1, iss_ready=0) changes nothing; ID must hold the instruction.

## Timing
- Reset (reset=0 at an edge):
  - all registers, counters and sb_err become 0;
  - outputs thereafter: ra/rb_data=0, busy=0, iss_ready=1, sb_err=0, dbg_regs=0.
  - Reset overrides a simultaneous wb_en or iss_valid.
- Read latency 0 (combinational from array and counters). Write-to-read latency: 1 cycle without bypass, 0 with bypass.
- Issue-to-busy latency: 1 cycle (busy asserts the cycle after acc).
- Writeback clears busy from the next cycle, or from the same cycle with bypass when pend==1.
- Reset mid-operation discards all pending counts. The pipeline is flushed by the same reset.
- Address decoding wraps naturally within AW bits. No out-of-range addresses exist.

## Configuration
- PCPU_RF_BYPASS_EN defined:
  - If wb_en=1 and wb_addr==xx_addr, then xx_data = wb_data.
  - If additionally wb_tracked=1 and pend[wb_addr]==1, xx_busy=0 that cycle.
- PCPU_RF_BYPASS_EN undefined:
  - Reads return array contents only.
  - busy reflects registered counters only; the same-cycle write becomes visible the next cycle.

## Test plan
- Reset then read: hold reset=0 for 2 edges, release; ra_addr=5 → ra_data=0x0000, ra_busy=0, iss_ready=1, dbg_regs all 0.
- Write/read: wb_en=1, wb_addr=3, wb_data=0xBEEF, wb_tracked=0; next cycle rb_addr=3 → rb_data=0xBEEF. Same cycle → 0xBEEF only with PCPU_RF_BYPASS_EN, else 0x0000.
- Scoreboard saturation (PEND_W=2): issue iss_rd=2 three times → pend=3, ra_busy(2)=1, fourth iss_valid → iss_ready=0 and pend stays 3. A concurrent tracked wb to 2 → iss_ready=1, pend stays 3.
- Drain: three tracked writes to reg 2 (0x0001, 0x0002, 0x0003) → busy drops after the third, reg 2=0x0003, sb_err=0.
- Underflow: tracked write to reg 6 with pend=0, data 0x1234 → reg 6=0x1234, sb_err=1, sticky until reset=0.
- Reset mid-flight: pend[1]=2, wb_en=1 asserted in same cycle as reset=0 → all counters 0, reg 1=0x0000, sb_err=0.
